jtag_command_issuer: RTL and testbench



---
 rtl/jtag_command_issuer_pkg.sv | 33 +++
 rtl/jtag_command_issuer_if.sv | 52 +++++
 rtl/jtag_command_issuer.sv | 176 +++++++++++++++++
 tb/tb_jtag_command_issuer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_command_issuer_pkg.sv
// rtl/jtag_command_issuer_pkg.sv - shared command codes and state encoding for the JTAG command issuer
package jtag_command_issuer_pkg;

  localparam int BW_JTAG_CMD = 4;

  localparam logic [BW_JTAG_CMD-1:0] JTAG_CMD_MEMORY_READ  = 4'h1;
  localparam logic [BW_JTAG_CMD-1:0] JTAG_CMD_MEMORY_WRITE = 4'h2;
  localparam logic [BW_JTAG_CMD-1:0] JTAG_CMD_SYSTEM_READ  = 4'h3;
  localparam logic [BW_JTAG_CMD-1:0] JTAG_CMD_SYSTEM_WRITE = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_SEND_ADDR,
    ST_SEND_WDATA,
    ST_WAIT_STATUS,
    ST_WAIT_RDATA,
    ST_RESPOND
  } issuer_state_t;

  // Picks the command code for a bus/direction pair.
  function automatic logic [BW_JTAG_CMD-1:0] cmd_code(input logic write, input logic system);
    logic [BW_JTAG_CMD-1:0] code;
    case ({system, write})
      2'b00:   code = JTAG_CMD_MEMORY_READ;
      2'b01:   code = JTAG_CMD_MEMORY_WRITE;
      2'b10:   code = JTAG_CMD_SYSTEM_READ;
      default: code = JTAG_CMD_SYSTEM_WRITE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/jtag_command_issuer_if.sv
// rtl/jtag_command_issuer_if.sv - request, command stream, status stream and response bundle
interface jtag_command_issuer_if #(
  parameter int BW_ADDR = 32,
  parameter int BW_DATA = 32
);

  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic               req_system;
  logic [BW_ADDR-1:0] req_addr;
  logic [BW_DATA-1:0] req_wdata;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [BW_DATA-1:0] cmd_data;

  logic               sts_valid;
  logic               sts_ready;
  logic [BW_DATA-1:0] sts_data;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_error;
  logic               rsp_timeout;
  logic [BW_DATA-1:0] rsp_rdata;

  // Host bridge plus executor side.
  modport master (
    output req_valid, req_write, req_system, req_addr, req_wdata,
    input  req_ready,
    input  cmd_valid, cmd_data,
    output cmd_ready,
    output sts_valid, sts_data,
    input  sts_ready,
    input  rsp_valid, rsp_error, rsp_timeout, rsp_rdata,
    output rsp_ready
  );

  // Issuer side.
  modport slave (
    input  req_valid, req_write, req_system, req_addr, req_wdata,
    output req_ready,
    output cmd_valid, cmd_data,
    input  cmd_ready,
    input  sts_valid, sts_data,
    output sts_ready,
    output rsp_valid, rsp_error, rsp_timeout, rsp_rdata,
    input  rsp_ready
  );

endinterface

// File: rtl/jtag_command_issuer.sv
// rtl/jtag_command_issuer.sv - serialises one access into the JTAG command word stream and collects its response
module jtag_command_issuer
  import jtag_command_issuer_pkg::*;
#(
  parameter int BW_ADDR        = 32,
  parameter int BW_DATA        = 32,
  parameter int BW_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  clk,
  input logic                  rstnn,
  jtag_command_issuer_if.slave bus
);

  localparam logic [BW_TIMEOUT-1:0] TMO_LIMIT = BW_TIMEOUT'(TIMEOUT_CYCLES);
  localparam bit                    TMO_EN    = (TIMEOUT_CYCLES != 0);

  issuer_state_t       state_q, state_n;
  logic                write_q, write_n;
  logic [BW_ADDR-1:0]  addr_q, addr_n;
  logic [BW_DATA-1:0]  wdata_q, wdata_n;
  logic [BW_DATA-1:0]  cmd_data_q, cmd_data_n;
  logic                rsp_error_q, rsp_error_n;
  logic                rsp_timeout_q, rsp_timeout_n;
  logic [BW_DATA-1:0]  rsp_rdata_q, rsp_rdata_n;
  logic [BW_TIMEOUT-1:0] tcnt_q, tcnt_n;
  logic [1:0]          discard_q, discard_n;
  logic                req_ready_q, cmd_valid_q, sts_ready_q, rsp_valid_q;
  logic                req_ready_n, cmd_valid_n, sts_ready_n, rsp_valid_n;

  logic                req_fire, cmd_fire, sts_fire;
  logic [BW_TIMEOUT:0] tcnt_inc;
  logic                tmo_hit;

  assign req_fire = bus.req_valid & req_ready_q;
  assign cmd_fire = cmd_valid_q & bus.cmd_ready;
  assign sts_fire = bus.sts_valid & sts_ready_q;

  // The wait counter never wraps: it stops at the limit, or at all-ones when disabled.
  assign tcnt_inc = {1'b0, tcnt_q} + {{BW_TIMEOUT{1'b0}}, 1'b1};
  assign tmo_hit  = TMO_EN && (tcnt_inc >= {1'b0, TMO_LIMIT});

  // Next-state, datapath and counter decisions for the transfer sequence.
  always_comb begin
    state_n       = state_q;
    write_n       = write_q;
    addr_n        = addr_q;
    wdata_n       = wdata_q;
    cmd_data_n    = cmd_data_q;
    rsp_error_n   = rsp_error_q;
    rsp_timeout_n = rsp_timeout_q;
    rsp_rdata_n   = rsp_rdata_q;
    tcnt_n        = tcnt_q;
    discard_n     = discard_q;

    // Late words from a timed-out transfer are swallowed before any new status is believed.
    if (sts_fire && (discard_q != 2'd0) && (state_q != ST_WAIT_RDATA))
      discard_n = discard_q - 2'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          write_n    = bus.req_write;
          addr_n     = bus.req_addr;
          wdata_n    = bus.req_wdata;
          cmd_data_n = BW_DATA'(cmd_code(bus.req_write, bus.req_system));
          state_n    = ST_SEND_CMD;
        end
      end
      ST_SEND_CMD: begin
        if (cmd_fire) begin
          cmd_data_n = BW_DATA'(addr_q);
          state_n    = ST_SEND_ADDR;
        end
      end
      ST_SEND_ADDR: begin
        if (cmd_fire) begin
          tcnt_n = '0;
          if (write_q) begin
            cmd_data_n = wdata_q;
            state_n    = ST_SEND_WDATA;
          end else begin
            state_n = ST_WAIT_STATUS;
          end
        end
      end
      ST_SEND_WDATA: begin
        if (cmd_fire) begin
          tcnt_n  = '0;
          state_n = ST_WAIT_STATUS;
        end
      end
      ST_WAIT_STATUS: begin
        if (sts_fire) begin
          if (discard_q == 2'd0) begin
            rsp_error_n   = bus.sts_data[0];
            rsp_timeout_n = 1'b0;
            rsp_rdata_n   = '0;
            state_n       = write_q ? ST_RESPOND : ST_WAIT_RDATA;
          end
        end else if (tmo_hit) begin
          tcnt_n        = TMO_LIMIT;
          rsp_error_n   = 1'b1;
          rsp_timeout_n = 1'b1;
          rsp_rdata_n   = '0;
          discard_n     = write_q ? 2'd1 : 2'd2;
          state_n       = ST_RESPOND;
        end else if (!(&tcnt_q)) begin
          tcnt_n = tcnt_inc[BW_TIMEOUT-1:0];
        end
      end
      ST_WAIT_RDATA: begin
        if (sts_fire) begin
          rsp_rdata_n = bus.sts_data;
          state_n     = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (bus.rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign req_ready_n = (state_n == ST_IDLE);
  assign cmd_valid_n = (state_n == ST_SEND_CMD) || (state_n == ST_SEND_ADDR) ||
                       (state_n == ST_SEND_WDATA);
  assign sts_ready_n = (state_n == ST_WAIT_STATUS) || (state_n == ST_WAIT_RDATA) ||
                       (discard_n != 2'd0);
  assign rsp_valid_n = (state_n == ST_RESPOND);

  // State and every handshake/data output are registered; reset silently drops any transfer.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cmd_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      tcnt_q        <= '0;
      discard_q     <= 2'd0;
      req_ready_q   <= 1'b0;
      cmd_valid_q   <= 1'b0;
      sts_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_n;
      write_q       <= write_n;
      addr_q        <= addr_n;
      wdata_q       <= wdata_n;
      cmd_data_q    <= cmd_data_n;
      rsp_error_q   <= rsp_error_n;
      rsp_timeout_q <= rsp_timeout_n;
      rsp_rdata_q   <= rsp_rdata_n;
      tcnt_q        <= tcnt_n;
      discard_q     <= discard_n;
      req_ready_q   <= req_ready_n;
      cmd_valid_q   <= cmd_valid_n;
      sts_ready_q   <= sts_ready_n;
      rsp_valid_q   <= rsp_valid_n;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_data    = cmd_data_q;
  assign bus.sts_ready   = sts_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_jtag_command_issuer.sv
// tb/tb_jtag_command_issuer.sv - self-checking bench for jtag_command_issuer
module tb_jtag_command_issuer;
  import jtag_command_issuer_pkg::*;

  logic clk = 1'b0;
  logic rstnn = 1'b0;
  always #5 clk = ~clk;

  jtag_command_issuer_if #(.BW_ADDR(32), .BW_DATA(32)) bus ();

  jtag_command_issuer #(
    .BW_ADDR(32), .BW_DATA(32), .BW_TIMEOUT(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rstnn(rstnn), .bus(bus)
  );

  typedef struct packed {
    logic        err;
    logic        tmo;
    logic [31:0] rdata;
  } rsp_t;

  logic [31:0] exp_cmd[$];
  rsp_t        exp_rsp[$];
  logic [31:0] log_word[$];
  int          log_cyc[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_sts_cyc = 0;
  int rsp_rise_cyc = 0;
  int cmd_mode = 0;
  logic cmd_force = 1'b0;

  logic        pc_stall = 1'b0;
  logic [31:0] pc_data = '0;
  logic        pr_hold = 1'b0;
  rsp_t        pr_rsp = '0;
  logic        prev_rsp_valid = 1'b0;

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Transaction-level model: the words an executor must see, and the response the host must get.
  function automatic void expect_txn(input logic w, input logic s, input logic [31:0] a,
                                     input logic [31:0] d);
    logic [31:0] code;
    case ({s, w})
      2'b00:   code = 32'(JTAG_CMD_MEMORY_READ);
      2'b01:   code = 32'(JTAG_CMD_MEMORY_WRITE);
      2'b10:   code = 32'(JTAG_CMD_SYSTEM_READ);
      default: code = 32'(JTAG_CMD_SYSTEM_WRITE);
    endcase
    exp_cmd.push_back(code);
    exp_cmd.push_back(a);
    if (w) exp_cmd.push_back(d);
  endfunction

  function automatic void expect_rsp(input logic err, input logic tmo, input logic [31:0] rdata);
    rsp_t r;
    r.err = err;
    r.tmo = tmo;
    r.rdata = rdata;
    exp_rsp.push_back(r);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Executor-side ready pattern: 0 = always ready, 1 = toggling, 2 = forced by the main sequence.
  initial begin
    bus.cmd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (cmd_mode)
        0:       bus.cmd_ready = 1'b1;
        1:       bus.cmd_ready = ~bus.cmd_ready;
        default: bus.cmd_ready = cmd_force;
      endcase
    end
  end

  // Compare process: checks every accepted word, every response and the hold rules each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstnn) begin
        pc_stall = 1'b0;
        pr_hold = 1'b0;
        prev_rsp_valid = 1'b0;
      end else begin
        if (pc_stall) begin
          check_bit("cmd_valid_held", bus.cmd_valid, 1'b1);
          check_word("cmd_data_held", bus.cmd_data, pc_data);
        end
        if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
        if (bus.cmd_valid && bus.cmd_ready) begin
          if (exp_cmd.size() == 0) check_bit("cmd_unexpected", 1'b1, 1'b0);
          else check_word("cmd_word", bus.cmd_data, exp_cmd.pop_front());
          log_word.push_back(bus.cmd_data);
          log_cyc.push_back(cyc);
        end
        pc_stall = bus.cmd_valid && !bus.cmd_ready;
        pc_data = bus.cmd_data;
        if (bus.sts_valid && bus.sts_ready) last_sts_cyc = cyc;
        if (pr_hold) begin
          check_bit("rsp_valid_held", bus.rsp_valid, 1'b1);
          check_bit("rsp_error_held", bus.rsp_error, pr_rsp.err);
          check_bit("rsp_timeout_held", bus.rsp_timeout, pr_rsp.tmo);
          check_word("rsp_rdata_held", bus.rsp_rdata, pr_rsp.rdata);
        end
        if (bus.rsp_valid) begin
          check_bit("req_ready_during_rsp", bus.req_ready, 1'b0);
          if (!prev_rsp_valid) begin
            rsp_rise_cyc = cyc;
            if (exp_rsp.size() != 0 && !exp_rsp[0].tmo)
              check_word("rsp_latency", 32'(cyc - last_sts_cyc), 32'd1);
          end
          if (bus.rsp_ready) begin
            if (exp_rsp.size() == 0) check_bit("rsp_unexpected", 1'b1, 1'b0);
            else begin
              rsp_t e;
              e = exp_rsp.pop_front();
              check_bit("rsp_error", bus.rsp_error, e.err);
              check_bit("rsp_timeout", bus.rsp_timeout, e.tmo);
              check_word("rsp_rdata", bus.rsp_rdata, e.rdata);
            end
          end
        end
        pr_hold = bus.rsp_valid && !bus.rsp_ready;
        pr_rsp.err = bus.rsp_error;
        pr_rsp.tmo = bus.rsp_timeout;
        pr_rsp.rdata = bus.rsp_rdata;
        prev_rsp_valid = bus.rsp_valid;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic s, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_system = s;
    bus.req_addr = a;
    bus.req_wdata = d;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 100);
    check_bit("req_accept_bound", bus.req_ready, 1'b1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic send_sts(input logic [31:0] w);
    int n = 0;
    bus.sts_valid = 1'b1;
    bus.sts_data = w;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.sts_ready && n < 100);
    check_bit("sts_accept_bound", bus.sts_ready, 1'b1);
    step();
    bus.sts_valid = 1'b0;
    bus.sts_data = '0;
  endtask

  task automatic wait_cmd_done();
    int n = 0;
    while (exp_cmd.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_bit("cmd_stream_bound", exp_cmd.size() == 0, 1'b1);
    step();
  endtask

  task automatic wait_rsp_done();
    int n = 0;
    while (exp_rsp.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_bit("rsp_bound", exp_rsp.size() == 0, 1'b1);
    step();
  endtask

  task automatic check_idle_outputs(input string tag, input logic rr);
    check_bit({tag, "_req_ready"}, bus.req_ready, rr);
    check_bit({tag, "_cmd_valid"}, bus.cmd_valid, 1'b0);
    check_bit({tag, "_sts_ready"}, bus.sts_ready, 1'b0);
    check_bit({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check_word({tag, "_cmd_data"}, bus.cmd_data, 32'h0);
    check_bit({tag, "_rsp_error"}, bus.rsp_error, 1'b0);
    check_bit({tag, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
    check_word({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
  endtask

  initial begin
    int last_c;
    int n;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_system = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.sts_valid = 1'b0;
    bus.sts_data = '0;
    bus.rsp_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset", 1'b0);
    step();
    rstnn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("post_reset", 1'b1);
    step();

    // Memory write, executor always ready.
    log_word.delete();
    log_cyc.delete();
    expect_txn(1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF);
    expect_rsp(1'b0, 1'b0, 32'h0);
    do_req(1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF);
    wait_cmd_done();
    send_sts(32'h0);
    wait_rsp_done();
    check_word("t1_nwords", log_word.size(), 32'd3);
    if (log_word.size() >= 3) begin
      check_word("t1_word0", log_word[0], 32'h0000_0002);
      check_word("t1_word1", log_word[1], 32'h8000_0010);
      check_word("t1_word2", log_word[2], 32'hDEAD_BEEF);
      check_word("t1_first_latency", 32'(log_cyc[0] - acc_cyc), 32'd1);
      check_word("t1_back_to_back", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
    end

    // System read.
    log_word.delete();
    log_cyc.delete();
    expect_txn(1'b0, 1'b1, 32'h0000_0400, 32'h0);
    expect_rsp(1'b0, 1'b0, 32'h1234_5678);
    do_req(1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF);
    wait_cmd_done();
    send_sts(32'h0);
    send_sts(32'h1234_5678);
    wait_rsp_done();
    check_word("t2_nwords", log_word.size(), 32'd2);
    if (log_word.size() >= 1) check_word("t2_word0", log_word[0], 32'h0000_0003);

    // Memory read with a stalling executor and an error status.
    cmd_mode = 1;
    expect_txn(1'b0, 1'b0, 32'h1000_0020, 32'h0);
    expect_rsp(1'b1, 1'b0, 32'h0BAD_F00D);
    do_req(1'b0, 1'b0, 32'h1000_0020, 32'h0);
    wait_cmd_done();
    send_sts(32'h1);
    send_sts(32'h0BAD_F00D);
    wait_rsp_done();
    cmd_mode = 0;
    step();

    // Read that never gets a status: timeout, then the late words are discarded.
    log_word.delete();
    log_cyc.delete();
    expect_txn(1'b0, 1'b0, 32'h2000_0000, 32'h0);
    expect_rsp(1'b1, 1'b1, 32'h0);
    do_req(1'b0, 1'b0, 32'h2000_0000, 32'h0);
    wait_cmd_done();
    last_c = (log_cyc.size() != 0) ? log_cyc[log_cyc.size()-1] : 0;
    wait_rsp_done();
    check_word("t4_timeout_cycle", 32'(rsp_rise_cyc - last_c), 32'd9);
    @(negedge clk);
    check_bit("t4_discard_ready_idle", bus.sts_ready, 1'b1);
    check_bit("t4_req_ready_idle", bus.req_ready, 1'b1);
    step();
    send_sts(32'h0);
    send_sts(32'hAAAA_5554);
    @(negedge clk);
    check_bit("t4_discard_drained", bus.sts_ready, 1'b0);
    step();
    expect_txn(1'b1, 1'b0, 32'h0000_0030, 32'h0000_0055);
    expect_rsp(1'b1, 1'b0, 32'h0);
    do_req(1'b1, 1'b0, 32'h0000_0030, 32'h0000_0055);
    wait_cmd_done();
    send_sts(32'h1);
    wait_rsp_done();

    // Reset while the address word is stalled.
    cmd_mode = 2;
    cmd_force = 1'b0;
    step();
    expect_txn(1'b0, 1'b0, 32'h4444_0000, 32'h0);
    do_req(1'b0, 1'b0, 32'h4444_0000, 32'h0);
    cmd_force = 1'b1;
    step();
    cmd_force = 1'b0;
    @(negedge clk);
    check_bit("t5_addr_valid", bus.cmd_valid, 1'b1);
    check_word("t5_addr_word", bus.cmd_data, 32'h4444_0000);
    step();
    rstnn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("t5_in_reset", 1'b0);
    step();
    rstnn = 1'b1;
    exp_cmd.delete();
    exp_rsp.delete();
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("t5_after_reset", 1'b1);
    cmd_mode = 0;
    step();
    expect_txn(1'b1, 1'b1, 32'h0000_0100, 32'h0101_0101);
    expect_rsp(1'b0, 1'b0, 32'h0);
    do_req(1'b1, 1'b1, 32'h0000_0100, 32'h0101_0101);
    wait_cmd_done();
    send_sts(32'h0);
    wait_rsp_done();

    // Response held while the host is not ready.
    bus.rsp_ready = 1'b0;
    expect_txn(1'b0, 1'b1, 32'h0000_0200, 32'h0);
    expect_rsp(1'b1, 1'b0, 32'hCAFE_0001);
    do_req(1'b0, 1'b1, 32'h0000_0200, 32'h0);
    wait_cmd_done();
    send_sts(32'h3);
    send_sts(32'hCAFE_0001);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_bit("t6_rsp_seen", bus.rsp_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      #1;
    end
    check_bit("t6_rsp_still_valid", bus.rsp_valid, 1'b1);
    check_word("t6_rdata_pinned", bus.rsp_rdata, 32'hCAFE_0001);
    step();
    bus.rsp_ready = 1'b1;
    wait_rsp_done();

    check_word("end_cmd_queue_empty", exp_cmd.size(), 32'd0);
    check_word("end_rsp_queue_empty", exp_rsp.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
